// File: rtl/inta_sequencer.sv
// 8259A 8086-mode two-pulse INTA sequencer: INT request, level latch, vector drive, AEOI clear.
// Optional ACK_TIMEOUT_EN aborts a sequence whose second INTA never arrives.
module inta_sequencer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       interrupt_pending,
   input  logic [7:0] highest_priority_interrupt,
   input  logic       inta_n,
   input  logic [4:0] vector_base,
   input  logic       auto_eoi,
   output logic       int_out,
   output logic       acknowledge,
   output logic [7:0] ack_level,
   output logic [7:0] end_of_interrupt,
   output logic [7:0] data_out,
   output logic       data_out_enable,
   output logic       freeze
);

   typedef enum logic [2:0] {IDLE, REQ, ACK1, WAIT2, ACK2} state_t;

   if (TIMEOUT_CYCLES < 4) begin : g_param_check
      $error("TIMEOUT_CYCLES must be at least 4");
   end

   state_t     state_q, state_d;
   logic       inta_prev_q;
   logic       int_out_q, int_out_d;
   logic       ack_q, ack_d;
   logic [7:0] level_q, level_d;
   logic [7:0] eoi_q, eoi_d;
   logic [7:0] data_q, data_d;
   logic       den_q, den_d;
   logic       freeze_q, freeze_d;
   logic       spurious_q, spurious_d;
   logic       fall, rise;
   logic [7:0] winner;

`ifdef ACK_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   function automatic logic [2:0] bit_index(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd7;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   assign fall   = inta_prev_q & ~inta_n;
   assign rise   = ~inta_prev_q & inta_n;
   // Isolate the lowest set bit so multiple requests resolve to the lowest index.
   assign winner = highest_priority_interrupt & (~highest_priority_interrupt + 8'd1);

   always_comb begin
      state_d    = state_q;
      int_out_d  = 1'b0;
      ack_d      = 1'b0;
      level_d    = level_q;
      eoi_d      = 8'h00;
      data_d     = data_q;
      den_d      = den_q;
      freeze_d   = freeze_q;
      spurious_d = spurious_q;
`ifdef ACK_TIMEOUT_EN
      cnt_d      = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (interrupt_pending) state_d = REQ;
         end
         REQ: begin
            int_out_d = 1'b1;
            if (fall) begin
               int_out_d  = 1'b0;
               level_d    = winner;
               ack_d      = |winner;
               spurious_d = ~|winner;
               freeze_d   = 1'b1;
               state_d    = ACK1;
`ifdef ACK_TIMEOUT_EN
               cnt_d      = '0;
`endif
            end
         end
         ACK1: begin
            if (rise) state_d = WAIT2;
         end
         WAIT2: begin
            if (fall) begin
               den_d   = 1'b1;
               data_d  = {vector_base, spurious_q ? 3'd7 : bit_index(level_q)};
               state_d = ACK2;
            end
         end
         ACK2: begin
            if (rise) begin
               den_d    = 1'b0;
               data_d   = 8'h00;
               freeze_d = 1'b0;
               if (auto_eoi && !spurious_q) eoi_d = level_q;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef ACK_TIMEOUT_EN
      // Abort only while still waiting for the second fall.
      if ((state_q == ACK1 || state_q == WAIT2) && state_d != ACK2) begin
         if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
            eoi_d    = spurious_q ? 8'h00 : level_q;
            freeze_d = 1'b0;
            state_d  = IDLE;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         inta_prev_q <= 1'b1;
         int_out_q   <= 1'b0;
         ack_q       <= 1'b0;
         level_q     <= 8'h00;
         eoi_q       <= 8'h00;
         data_q      <= 8'h00;
         den_q       <= 1'b0;
         freeze_q    <= 1'b0;
         spurious_q  <= 1'b0;
`ifdef ACK_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         inta_prev_q <= inta_n;
         int_out_q   <= int_out_d;
         ack_q       <= ack_d;
         level_q     <= level_d;
         eoi_q       <= eoi_d;
         data_q      <= data_d;
         den_q       <= den_d;
         freeze_q    <= freeze_d;
         spurious_q  <= spurious_d;
`ifdef ACK_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign int_out          = int_out_q;
   assign acknowledge      = ack_q;
   assign ack_level        = level_q;
   assign end_of_interrupt = eoi_q;
   assign data_out         = data_q;
   assign data_out_enable  = den_q;
   assign freeze           = freeze_q;

endmodule

// File: doc/inta_sequencer.md
# inta_sequencer

Sequences the two-pulse 8086-mode interrupt acknowledge cycle of the 8259A controller. Sits between the priority resolver and the ISR block: raises INT toward the CPU, latches the winning request on the first INTA pulse and pulses `acknowledge` so the ISR sets that bit. Drives the interrupt vector onto the data bus during the second INTA pulse and, in automatic-EOI mode, issues the clear back to the ISR.

## Interface
- TIMEOUT_CYCLES, 64, cycles allowed from first INTA fall to second INTA fall before abort (only with the timeout feature compiled in); minimum 4.
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- interrupt_pending  in  1  resolver reports an unmasked request of higher priority than anything in service
- highest_priority_interrupt  in  8  resolver winner, one-hot; multiple bits set -> lowest index wins
- inta_n  in  1  CPU acknowledge strobe, active-low, already synchronised to clk
- vector_base  in  5  ICW2 T7..T3
- auto_eoi  in  1  1 = automatic EOI mode
- int_out  out  1  interrupt request to CPU
- acknowledge  out  1  one-cycle pulse to ISR, set bit `ack_level`
- ack_level  out  8  latched one-hot level being acknowledged (0 when spurious)
- end_of_interrupt  out  8  one-cycle AEOI/abort clear mask to ISR
- data_out  out  8  vector byte
- data_out_enable  out  1  bus driver enable for `data_out`
- freeze  out  1  hold IRR edge latches stable while high

## Operation
- Edge detect: `inta_prev` register (reset 1). fall = inta_prev & ~inta_n; rise = ~inta_prev & inta_n.
- States: IDLE, REQ, ACK1, WAIT2, ACK2.
- IDLE: if interrupt_pending -> REQ.
- REQ: int_out=1. On fall: latch winner of highest_priority_interrupt into ack_level; if winner nonzero, pulse acknowledge; else set spurious flag, ack_level=0, no acknowledge. Set freeze; -> ACK1. If interrupt_pending drops before fall, stay in REQ (CPU will still acknowledge; resolves as spurious).
- ACK1: int_out=0, freeze=1. On rise -> WAIT2.
- WAIT2: on fall -> ACK2.
- ACK2: data_out = {vector_base, index(ack_level)}, index 3'd7 when spurious; data_out_enable=1. On rise: data_out_enable=0, freeze=0; if auto_eoi & !spurious, pulse end_of_interrupt=ack_level; -> IDLE.
- Inputs highest_priority_interrupt, vector_base, auto_eoi are sampled at the points above only; later changes are ignored for that cycle sequence. auto_eoi is sampled at the second rise.
- end_of_interrupt is 0 in all cycles except the single pulse cycle.

## Timing
- Reset values: int_out=0, acknowledge=0, ack_level=0, end_of_interrupt=0, data_out=0, data_out_enable=0, freeze=0, state IDLE, spurious=0.
- All outputs registered. An event detected at edge N is visible after edge N.
- interrupt_pending high at edge N -> int_out=1 after edge N+1 (IDLE->REQ at N, int_out registered from REQ).
- First fall sampled at edge N: acknowledge=1, freeze=1 and int_out=0 for the cycle after N only (acknowledge); freeze holds until the second rise.
- Second fall at edge M: data_out_enable=1 after M; second rise at edge R: data_out_enable=0 and AEOI pulse after R, state IDLE after R.
- IDLE re-arm: interrupt_pending high at the edge following return to IDLE starts a new sequence; minimum gap between INT assertions is 1 cycle.
- Reset mid-sequence: all outputs to reset values after the reset edge; no EOI or abort pulse issued; ISR bit already set remains (software clears).
- INTA falls in IDLE, or a fall in ACK1, are ignored.

## Configuration
- ACK_TIMEOUT_EN defined: counter starts at first fall, counts in ACK1/WAIT2; if it reaches TIMEOUT_CYCLES before the second fall, abort: pulse end_of_interrupt=ack_level (skipped if spurious), clear freeze, -> IDLE. Counter width = clog2(TIMEOUT_CYCLES+1).
- Not defined: no counter; WAIT2 waits indefinitely; TIMEOUT_CYCLES unused.

## Test plan
- Reset then idle: all outputs 0, int_out stays 0 with interrupt_pending=0 for 20 cycles.
- Normal, auto_eoi=0: pending with highest=8'b0010_0000, vector_base=5'b01000, two INTA pulses -> int_out 1, acknowledge pulse with ack_level=8'h20, data_out=8'h45 with enable during second pulse, end_of_interrupt stays 0.
- AEOI: same with auto_eoi=1, highest=8'h01 -> data_out=8'h40, end_of_interrupt=8'h01 one cycle after second rise.
- Spurious: pending asserted then highest=0 before first fall -> no acknowledge, ack_level=0, data_out=8'h47, no EOI even with auto_eoi=1.
- Multi-bit highest=8'b1001_0100 -> ack_level=8'h04; change highest between pulses -> vector unchanged.
- Reset asserted in WAIT2 -> all outputs 0 next cycle, no EOI; with ACK_TIMEOUT_EN and TIMEOUT_CYCLES=8, withhold second pulse -> end_of_interrupt=ack_level pulse, return to IDLE.
